// File: rtl/pio_bank_irq_pkg.sv
// pio_pkg: register map offsets, edge-mode encoding and ID magic for pio_bank_irq
package pio_pkg;
  localparam logic [5:0] OUT_BASE  = 6'h00;
  localparam logic [5:0] SET_BASE  = 6'h08;
  localparam logic [5:0] CLR_BASE  = 6'h0C;
  localparam logic [5:0] IN_BASE   = 6'h10;
  localparam logic [5:0] EDGE_BASE = 6'h20;
  localparam logic [5:0] MASK_BASE = 6'h30;
  localparam logic [5:0] ID_ADDR   = 6'h3F;
  localparam logic [7:0] ID_MAGIC  = 8'hB1;
  localparam int SETCLR_WORDS = 4;
  typedef enum logic [1:0] {EDGE_RISE = 2'd0, EDGE_FALL = 2'd1, EDGE_ANY = 2'd2} edge_mode_e;
endpackage

// File: rtl/pio_bank_irq_if.sv
// pio_bank_irq_if: Avalon-MM slave bus bundle, readdata has fixed latency 1
interface pio_bank_irq_if;
  logic [5:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/pio_bank_irq_in_channel.sv
// pio_in_channel: per-word input synchroniser, optional debounce (PIO_DEBOUNCE_EN), edge pulse
module pio_in_channel
  import pio_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter logic [1:0]  EDGE_MODE  = 2'd0,
  parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_i,
  output logic [DATA_W-1:0] v_o,
  output logic [DATA_W-1:0] edge_o
);
  logic [DATA_W-1:0] meta_q, sync_q, prev_q;
  // two-flop synchroniser plus the previous conditioned value for edge detection
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= in_i;
      sync_q <= meta_q;
      prev_q <= v_o;
    end
`ifdef PIO_DEBOUNCE_EN
  logic [DATA_W-1:0] cand_q, v_q, v_d;
  logic [15:0]       cnt_q, cnt_d;
  // counter tracks how long the synchronised word has matched the candidate; saturates
  always_comb begin
    cnt_d = (sync_q != cand_q) ? 16'd1 : (&cnt_q ? cnt_q : cnt_q + 16'd1);
    v_d   = (sync_q == cand_q && cnt_q >= DEB_CYCLES - 16'd1) ? cand_q : v_q;
  end
  // debounce state
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cand_q <= '0;
      cnt_q  <= '0;
      v_q    <= '0;
    end else begin
      cand_q <= sync_q;
      cnt_q  <= cnt_d;
      v_q    <= v_d;
    end
  assign v_o = v_q;
`else
  assign v_o = sync_q;
`endif
  assign edge_o = (EDGE_MODE == EDGE_FALL) ? ~v_o & prev_q :
                  (EDGE_MODE == EDGE_ANY)  ? v_o ^ prev_q  : v_o & ~prev_q;
endmodule

// File: rtl/pio_bank_irq.sv
// pio_bank_irq: Avalon-MM PIO bank with set/clear outputs, edge capture and masked irq; optional PIO_DEBOUNCE_EN
module pio_bank_irq
  import pio_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          NUM_OUT    = 4,
  parameter int          NUM_IN     = 3,
  parameter logic [31:0] OUT_RESET  = 32'h0,
  parameter logic [1:0]  EDGE_MODE  = 2'd0,
  parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  pio_bank_irq_if.slave             bus,
  output logic                      irq,
  output logic [NUM_OUT*DATA_W-1:0] out_export,
  input  logic [NUM_IN*DATA_W-1:0]  in_export
);
  logic [DATA_W-1:0] out_q [NUM_OUT];
  logic [DATA_W-1:0] out_d [NUM_OUT];
  logic [DATA_W-1:0] edge_q [NUM_IN];
  logic [DATA_W-1:0] edge_d [NUM_IN];
  logic [DATA_W-1:0] mask_q [NUM_IN];
  logic [DATA_W-1:0] mask_d [NUM_IN];
  logic [DATA_W-1:0] in_v [NUM_IN];
  logic [DATA_W-1:0] in_edge [NUM_IN];
  logic [31:0]       rdata_q, rdata_d, rd_mux;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] wd;
  assign wd = bus.writedata[DATA_W-1:0];
  for (genvar j = 0; j < NUM_IN; j++) begin : g_in
    pio_in_channel #(.DATA_W(DATA_W), .EDGE_MODE(EDGE_MODE), .DEB_CYCLES(DEB_CYCLES)) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .in_i   (in_export[j*DATA_W +: DATA_W]),
      .v_o    (in_v[j]),
      .edge_o (in_edge[j])
    );
  end
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out_export[k*DATA_W +: DATA_W] = out_q[k];
  end
  // output words: direct write, plus set/clear aliases for the first four words only
  always_comb begin
    out_d = out_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (bus.write && bus.address == OUT_BASE + 6'(k)) out_d[k] = wd;
      if (bus.write && k < SETCLR_WORDS && bus.address == SET_BASE + 6'(k)) out_d[k] = out_q[k] | wd;
      if (bus.write && k < SETCLR_WORDS && bus.address == CLR_BASE + 6'(k)) out_d[k] = out_q[k] & ~wd;
    end
  end
  // edge capture with W1C where a same-cycle edge wins; masks; irq from the visible edge bits
  always_comb begin
    irq_d = 1'b0;
    for (int j = 0; j < NUM_IN; j++) begin
      edge_d[j] = ((bus.write && bus.address == EDGE_BASE + 6'(j)) ? edge_q[j] & ~wd : edge_q[j]) | in_edge[j];
      mask_d[j] = (bus.write && bus.address == MASK_BASE + 6'(j)) ? wd : mask_q[j];
      irq_d     = irq_d | (|(edge_q[j] & mask_q[j]));
    end
  end
  // read mux; readdata holds between reads
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_OUT; k++)
      if (bus.address == OUT_BASE + 6'(k)) rd_mux = 32'(out_q[k]);
    for (int j = 0; j < NUM_IN; j++) begin
      if (bus.address == IN_BASE + 6'(j))   rd_mux = 32'(in_v[j]);
      if (bus.address == EDGE_BASE + 6'(j)) rd_mux = 32'(edge_q[j]);
      if (bus.address == MASK_BASE + 6'(j)) rd_mux = 32'(mask_q[j]);
    end
    if (bus.address == ID_ADDR) rd_mux = {ID_MAGIC, 8'(NUM_IN), 8'(NUM_OUT), 8'(DATA_W)};
    rdata_d = bus.read ? rd_mux : rdata_q;
  end
  // register state
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_q   <= '{default: OUT_RESET[DATA_W-1:0]};
      edge_q  <= '{default: '0};
      mask_q  <= '{default: '0};
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  assign bus.readdata = rdata_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_pio_bank_irq.sv
// tb_pio_bank_irq: scoreboard bench for pio_bank_irq; read expectations queued, monitor compares
module tb_pio_bank_irq;
  import pio_pkg::*;
  localparam int DW = 32;
  localparam int NO = 4;
  localparam int NI = 3;
`ifdef PIO_DEBOUNCE_EN
  localparam int DLY = 8;
`else
  localparam int DLY = 0;
`endif
  typedef struct {string name; logic [31:0] exp;} exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic irq;
  logic [NO*DW-1:0] out_export;
  logic [NI*DW-1:0] in_export = '0;
  logic rd_pend;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  pio_bank_irq_if bus ();
  pio_bank_irq #(
    .DATA_W(DW), .NUM_OUT(NO), .NUM_IN(NI), .OUT_RESET(32'hA5), .EDGE_MODE(2'd0), .DEB_CYCLES(16'd8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq), .out_export(out_export), .in_export(in_export)
  );
  always #5 clk = ~clk;
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] ow(int k);
    return out_export[k*DW +: DW];
  endfunction
  always @(posedge clk or negedge reset_n) rd_pend <= !reset_n ? 1'b0 : bus.read;
  always @(negedge clk)
    if (rd_pend) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: got %h expected none", bus.readdata);
      end else begin
        e = sb.pop_front();
        check(e.name, bus.readdata, e.exp);
      end
    end
  task automatic issue_read(logic [5:0] a, logic [31:0] e, string nm);
    bus.address = a;
    bus.read = 1'b1;
    sb.push_back('{nm, e});
  endtask
  task automatic rd(logic [5:0] a, logic [31:0] e, string nm);
    @(negedge clk);
    issue_read(a, e, nm);
    @(negedge clk);
    bus.read = 1'b0;
  endtask
  task automatic wr(logic [5:0] a, logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    bus.writedata = d;
    bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask
  initial begin
    bus.address = '0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.writedata = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NO; k++) check($sformatf("reset_out%0d", k), ow(k), 32'hA5);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_readdata", bus.readdata, 32'h0);
    reset_n = 1'b1;
    rd(ID_ADDR, 32'hB1030420, "id");
    wr(OUT_BASE + 6'd1, 32'hF0);
    wr(SET_BASE + 6'd1, 32'h0F);
    wr(CLR_BASE + 6'd1, 32'h81);
    rd(OUT_BASE + 6'd1, 32'h7E, "out1_setclr");
    check("out_export1", ow(1), 32'h7E);
    rd(OUT_BASE, 32'hA5, "out0");
    wr(6'h05, 32'hFFFF_FFFF);
    @(negedge clk);
    check("oor_write_w0", ow(0), 32'hA5);
    check("oor_write_w1", ow(1), 32'h7E);
    check("oor_write_w2", ow(2), 32'hA5);
    check("oor_write_w3", ow(3), 32'hA5);
    rd(6'h1F, 32'h0, "unmapped_read");
    rd(IN_BASE + 6'd3, 32'h0, "in_oor_read");
    rd(ID_ADDR, 32'hB1030420, "id_again");
    repeat (3) @(negedge clk);
    check("readdata_hold", bus.readdata, 32'hB1030420);
    wr(MASK_BASE, 32'h1);
    rd(MASK_BASE, 32'h1, "mask0");
    @(negedge clk);
    in_export[0] = 1'b1;
    repeat (DLY) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("irq_2clk", 32'(irq), 32'h0);
    issue_read(EDGE_BASE, 32'h0, "edge0_2clk");
    @(negedge clk);
    check("irq_3clk", 32'(irq), 32'h0);
    issue_read(EDGE_BASE, 32'h1, "edge0_3clk");
    @(negedge clk);
    bus.read = 1'b0;
    check("irq_4clk", 32'(irq), 32'h1);
    rd(IN_BASE, 32'h1, "in0");
    wr(EDGE_BASE, 32'h1);
    @(negedge clk);
    check("irq_after_w1c", 32'(irq), 32'h0);
    rd(EDGE_BASE, 32'h0, "edge0_cleared");
    @(negedge clk);
    in_export[2*DW+5] = 1'b1;
    repeat (DLY) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.address = EDGE_BASE + 6'd2;
    bus.writedata = 32'h20;
    bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    rd(EDGE_BASE + 6'd2, 32'h20, "edge2_race");
    rd(IN_BASE + 6'd2, 32'h20, "in2");
    wr(EDGE_BASE + 6'd2, 32'h20);
    rd(EDGE_BASE + 6'd2, 32'h0, "edge2_w1c");
    @(negedge clk);
    in_export[2*DW+5] = 1'b0;
    repeat (4 + DLY) @(negedge clk);
    rd(EDGE_BASE + 6'd2, 32'h0, "edge2_fall_ignored");
    check("irq_masked_off", 32'(irq), 32'h0);
`ifdef PIO_DEBOUNCE_EN
    @(negedge clk);
    in_export[DW] = 1'b1;
    repeat (5) @(negedge clk);
    in_export[DW] = 1'b0;
    repeat (20) @(negedge clk);
    rd(IN_BASE + 6'd1, 32'h0, "deb_glitch_in");
    rd(EDGE_BASE + 6'd1, 32'h0, "deb_glitch_edge");
    @(negedge clk);
    in_export[DW] = 1'b1;
    repeat (12) @(negedge clk);
    rd(IN_BASE + 6'd1, 32'h1, "deb_level_in");
    rd(EDGE_BASE + 6'd1, 32'h1, "deb_level_edge");
`endif
    rd(ID_ADDR, 32'hB1030420, "id_before_reset");
    @(negedge clk);
    bus.address = OUT_BASE + 6'd1;
    bus.read = 1'b1;
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1 bus.read = 1'b0;
    check("reset_mid_read", bus.readdata, 32'h0);
    check("reset_out1", ow(1), 32'hA5);
    check("reset_irq2", 32'(irq), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(OUT_BASE + 6'd1, 32'hA5, "read_after_reset");
    rd(MASK_BASE, 32'h0, "mask_after_reset");
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
